// File: rtl/spc_pkg.sv
// Shared types, default parameters and bit-vector helpers for the self-purging controller.
package spc_pkg;

    localparam int SPC_N_DEF         = 6;
    localparam int SPC_THR_DEF       = 4;
    localparam int SPC_PERSIST_DEF   = 2;
    localparam int SPC_PROBE_LEN_DEF = 8;

    typedef enum logic [1:0] {
        ST_MONITOR = 2'd0,
        ST_PROBE   = 2'd1,
        ST_FAIL    = 2'd2
    } spc_state_e;

    // Number of set bits; callers zero-extend narrower vectors into 32 bits.
    function automatic logic [5:0] popcount(input logic [31:0] v);
        logic [5:0] c;
        c = 6'd0;
        for (int i = 0; i < 32; i++) begin
            c = c + {5'd0, v[i]};
        end
        return c;
    endfunction

    // Index of the lowest set bit, 0 when the vector is empty.
    function automatic logic [4:0] lowest_set(input logic [31:0] v);
        logic [4:0] idx;
        logic       found;
        idx   = 5'd0;
        found = 1'b0;
        for (int i = 0; i < 32; i++) begin
            if (v[i] && !found) begin
                idx   = 5'(i);
                found = 1'b1;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/self_purging_controller_purge_filter.sv
// Per-module persistence filter: owns one module's disagreement counter and its enable flop.
module purge_filter
    import spc_pkg::*;
#(
    parameter int PERSIST = SPC_PERSIST_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic i_valid,
    input  logic i_mismatch,
    input  logic i_probe,
    input  logic i_force_enable,
    input  logic i_freeze,
    output logic o_enable,
    output logic o_purge
);

    localparam int PW = $clog2(PERSIST + 1);

    logic [PW-1:0] r_cnt;
    logic          r_enable;
    logic          w_hit;

    // Probe modules drop on the first bad sample; normal ones on the PERSIST-th in a row.
    always_comb begin
        w_hit = 1'b0;
        if (r_enable && i_valid && i_mismatch && !i_freeze) begin
            if (i_probe) begin
                w_hit = 1'b1;
            end else if (32'(r_cnt) >= PERSIST - 1) begin
                w_hit = 1'b1;
            end else begin
                w_hit = 1'b0;
            end
        end else begin
            w_hit = 1'b0;
        end
    end

    // Counter and enable update; a disabled module keeps its counter parked at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= {PW{1'b0}};
            r_enable <= 1'b1;
        end else if (i_force_enable) begin
            r_cnt    <= {PW{1'b0}};
            r_enable <= 1'b1;
        end else if (i_freeze) begin
            r_cnt    <= r_cnt;
            r_enable <= r_enable;
        end else if (!r_enable) begin
            r_cnt    <= {PW{1'b0}};
        end else if (w_hit) begin
            r_cnt    <= {PW{1'b0}};
            r_enable <= 1'b0;
        end else if (i_valid && !i_probe) begin
            if (!i_mismatch) begin
                r_cnt <= {PW{1'b0}};
            end else if (32'(r_cnt) >= PERSIST) begin
                r_cnt <= r_cnt;
            end else begin
                r_cnt <= r_cnt + PW'(1);
            end
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign o_enable = r_enable;
    assign o_purge  = w_hit;

endmodule

// File: rtl/self_purging_controller.sv
// Sequencer for an N-module self-purging redundant datapath: purge, probe re-admission, failure.
// Optional event log (purge_total, last_purged) is built when SPC_EVENT_LOG_EN is defined.
module self_purging_controller
    import spc_pkg::*;
#(
    parameter int  N         = SPC_N_DEF,
    parameter int  THR       = SPC_THR_DEF,
    parameter int  PERSIST   = SPC_PERSIST_DEF,
    parameter int  PROBE_LEN = SPC_PROBE_LEN_DEF,
    localparam int CW        = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sample_valid,
    input  logic [N-1:0]  mismatch,
    input  logic          rearm,
    output logic [N-1:0]  enable,
    output logic [CW-1:0] active_cnt,
    output logic          purge_evt,
    output logic          busy,
    output logic          sys_fail
`ifdef SPC_EVENT_LOG_EN
    ,
    output logic [15:0]            purge_total,
    output logic [$clog2(N)-1:0]   last_purged
`endif
);

    localparam int PCW = $clog2(PROBE_LEN + 1);

    spc_state_e     r_state;
    logic [N-1:0]   r_probe_mask;
    logic [PCW-1:0] r_probe_cnt;
    logic [CW-1:0]  r_active_cnt;
    logic           r_purge_evt;
    logic           r_busy;
    logic           r_sys_fail;

    logic [N-1:0]   w_enable;
    logic [N-1:0]   w_purge;
    logic [N-1:0]   w_force;
    logic [N-1:0]   w_enable_kept;
    logic [CW-1:0]  w_kept_cnt;
    logic           w_any_purge;
    logic           w_fail_nxt;
    logic           w_start_probe;
    logic           w_probe_done;
    logic           w_freeze;

    for (genvar g = 0; g < N; g++) begin : g_filter
        purge_filter #(
            .PERSIST (PERSIST)
        ) u_filter (
            .clk            (clk),
            .rst            (rst),
            .i_valid        (sample_valid),
            .i_mismatch     (mismatch[g]),
            .i_probe        (r_probe_mask[g]),
            .i_force_enable (w_force[g]),
            .i_freeze       (w_freeze),
            .o_enable       (w_enable[g]),
            .o_purge        (w_purge[g])
        );
    end

    // A purge always lands; rearm is honoured only on a quiet MONITOR cycle with something to re-admit.
    always_comb begin
        w_freeze      = (r_state == ST_FAIL);
        w_any_purge   = |w_purge;
        w_enable_kept = w_enable & ~w_purge;
        w_kept_cnt    = CW'(popcount(32'(w_enable_kept)));
        w_fail_nxt    = w_any_purge && (32'(w_kept_cnt) < THR);
        w_start_probe = (r_state == ST_MONITOR) && rearm && !w_any_purge
                        && (w_enable != {N{1'b1}});
        w_probe_done  = (r_state == ST_PROBE) && sample_valid
                        && (32'(r_probe_cnt) == PROBE_LEN - 1);
        if (w_start_probe) begin
            w_force = ~w_enable;
        end else begin
            w_force = {N{1'b0}};
        end
    end

    // Mode sequencing, probe bookkeeping and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_MONITOR;
            r_probe_mask <= {N{1'b0}};
            r_probe_cnt  <= {PCW{1'b0}};
            r_active_cnt <= CW'(N);
            r_purge_evt  <= 1'b0;
            r_busy       <= 1'b0;
            r_sys_fail   <= 1'b0;
        end else begin
            r_purge_evt  <= w_any_purge;
            r_active_cnt <= w_start_probe ? CW'(N) : w_kept_cnt;
            case (r_state)
                ST_MONITOR: begin
                    if (w_fail_nxt) begin
                        r_state    <= ST_FAIL;
                        r_sys_fail <= 1'b1;
                    end else if (w_start_probe) begin
                        r_state      <= ST_PROBE;
                        r_probe_mask <= ~w_enable;
                        r_probe_cnt  <= {PCW{1'b0}};
                        r_busy       <= 1'b1;
                    end else begin
                        r_state <= ST_MONITOR;
                    end
                end
                ST_PROBE: begin
                    if (w_fail_nxt) begin
                        r_state      <= ST_FAIL;
                        r_sys_fail   <= 1'b1;
                        r_busy       <= 1'b0;
                        r_probe_mask <= {N{1'b0}};
                    end else if (w_probe_done) begin
                        r_state      <= ST_MONITOR;
                        r_busy       <= 1'b0;
                        r_probe_mask <= {N{1'b0}};
                        r_probe_cnt  <= {PCW{1'b0}};
                    end else begin
                        r_probe_mask <= r_probe_mask & ~w_purge;
                        if (sample_valid) begin
                            r_probe_cnt <= r_probe_cnt + PCW'(1);
                        end else begin
                            r_probe_cnt <= r_probe_cnt;
                        end
                    end
                end
                ST_FAIL: begin
                    r_state <= ST_FAIL;
                end
                default: begin
                    r_state    <= ST_FAIL;
                    r_sys_fail <= 1'b1;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    assign enable     = w_enable;
    assign active_cnt = r_active_cnt;
    assign purge_evt  = r_purge_evt;
    assign busy       = r_busy;
    assign sys_fail   = r_sys_fail;

`ifdef SPC_EVENT_LOG_EN
    localparam int LW = $clog2(N);

    logic [15:0]   r_purge_total;
    logic [LW-1:0] r_last_purged;
    logic [16:0]   w_total_sum;

    // Running total counts each module individually and saturates at 16 bits.
    always_comb begin
        w_total_sum = {1'b0, r_purge_total} + {11'd0, popcount(32'(w_purge))};
    end

    // Log update on every purge event.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_purge_total <= 16'd0;
            r_last_purged <= {LW{1'b0}};
        end else if (w_any_purge) begin
            r_purge_total <= w_total_sum[16] ? 16'hFFFF : w_total_sum[15:0];
            r_last_purged <= LW'(lowest_set(32'(w_purge)));
        end else begin
            r_purge_total <= r_purge_total;
            r_last_purged <= r_last_purged;
        end
    end

    assign purge_total = r_purge_total;
    assign last_purged = r_last_purged;
`endif

endmodule
